instr_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read interface. Owns the PC and issues

---
 rtl/instr_fetch_unit_if.sv | 21 ++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bus bundle: instruction-memory read port plus the
// valid/ready instruction hand-off to decode.
interface instr_fetch_unit_if;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  modport master (
    output imem_read, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, id_ready
  );

  modport slave (
    input  imem_read, imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, id_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory into a prefetch
// FIFO and presents the head to decode. Optional IFU_PERF_CNT_EN adds counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  instr_fetch_unit_if.master bus
);
  localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic [31:0]   instr_d [FIFO_DEPTH];
  logic [31:0]   addr_q  [FIFO_DEPTH];
  logic [31:0]   addr_d  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   last_instr_q, last_instr_d, last_pc_q, last_pc_d;
  logic          full, empty, fetch, pop;

  always_comb begin
    full  = (count_q == DEPTH_C);
    empty = (count_q == '0);
    // rst_n gates the request so imem_read drops the instant reset asserts
    fetch = rst_n && fetch_en && !redirect_valid && !full;
    pop   = !empty && bus.id_ready && !redirect_valid;

    pc_d         = pc_q;
    instr_d      = instr_q;
    addr_d       = addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_instr_d = last_instr_q;
    last_pc_d    = last_pc_q;

    // Shadow of the visible head so outputs hold their value once the FIFO empties
    if (!empty) begin
      last_instr_d = instr_q[rd_ptr_q];
      last_pc_d    = addr_q[rd_ptr_q];
    end

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch) begin
        instr_d[wr_ptr_q] = bus.imem_rdata;
        addr_d[wr_ptr_q]  = pc_q;
        wr_ptr_d          = wr_ptr_q + PW'(1);
        pc_d              = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(fetch) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      instr_q      <= '{default: '0};
      addr_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_instr_q <= '0;
      last_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_instr_q <= last_instr_d;
      last_pc_q    <= last_pc_d;
    end
  end

  assign bus.imem_read = fetch;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = !empty;
  assign bus.if_instr  = empty ? last_instr_q : instr_q[rd_ptr_q];
  assign bus.if_pc     = empty ? last_pc_q    : addr_q[rd_ptr_q];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (fetch_en && full && !redirect_valid) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (RESET_PC 0 and FFFF_FFFC) driven in
// lockstep and compared each cycle against a queue-based reference model.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;

  instr_fetch_unit_if bus0();
  instr_fetch_unit_if bus1();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2048_000A;
    if (a == 32'h4) return 32'h2849_000A;
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  assign bus0.imem_rdata = mem_word(bus0.imem_addr);
  assign bus1.imem_rdata = mem_word(bus1.imem_addr);
  assign bus0.id_ready   = id_ready;
  assign bus1.id_ready   = id_ready;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] pf[2], ps[2];
`endif

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u0 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt(pf[0]), .perf_stall_cnt(ps[0]),
`endif
    .bus(bus0)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt(pf[1]), .perf_stall_cnt(ps[1]),
`endif
    .bus(bus1)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t        mq[2][$];
  logic [31:0] mpc[2], mlast_pc[2], mlast_instr[2];
  logic [31:0] mfc[2], msc[2];
  logic        o_read[2], o_valid[2];
  logic [31:0] o_addr[2], o_instr[2], o_pc[2];

  function automatic logic [31:0] rpc(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      mpc[i] = rpc(i);
      mlast_pc[i] = '0;
      mlast_instr[i] = '0;
      mfc[i] = '0;
      msc[i] = '0;
    end
  endtask

  task automatic sample_and_compare();
    o_read[0] = bus0.imem_read; o_addr[0] = bus0.imem_addr; o_valid[0] = bus0.if_valid;
    o_instr[0] = bus0.if_instr; o_pc[0] = bus0.if_pc;
    o_read[1] = bus1.imem_read; o_addr[1] = bus1.imem_addr; o_valid[1] = bus1.if_valid;
    o_instr[1] = bus1.if_instr; o_pc[1] = bus1.if_pc;
    for (int i = 0; i < 2; i++) begin
      automatic int  n = mq[i].size();
      automatic bit  ev = (n > 0);
      automatic bit  er = rst_n && fetch_en && !redirect_valid && (n < DEPTH);
      chk($sformatf("u%0d_read", i), 32'(o_read[i]), 32'(er));
      chk($sformatf("u%0d_addr", i), o_addr[i], mpc[i]);
      chk($sformatf("u%0d_valid", i), 32'(o_valid[i]), 32'(ev));
      chk($sformatf("u%0d_instr", i), o_instr[i], ev ? mq[i][0].instr : mlast_instr[i]);
      chk($sformatf("u%0d_ifpc", i), o_pc[i], ev ? mq[i][0].pc : mlast_pc[i]);
`ifdef IFU_PERF_CNT_EN
      chk($sformatf("u%0d_perf_fetch", i), pf[i], mfc[i]);
      chk($sformatf("u%0d_perf_stall", i), ps[i], msc[i]);
`endif
    end
  endtask

  task automatic model_step();
    if (!rst_n) return;
    for (int i = 0; i < 2; i++) begin
      automatic int n = mq[i].size();
      automatic bit f = fetch_en && !redirect_valid && (n < DEPTH);
      if (n > 0) begin
        mlast_pc[i]    = mq[i][0].pc;
        mlast_instr[i] = mq[i][0].instr;
      end
      if (f) mfc[i] = mfc[i] + 1;
      if (fetch_en && n == DEPTH && !redirect_valid) msc[i] = msc[i] + 1;
      if (redirect_valid) begin
        mq[i].delete();
        mpc[i] = {redirect_pc[31:2], 2'b00};
      end else begin
        if (n > 0 && id_ready) void'(mq[i].pop_front());
        if (f) begin
          mq[i].push_back({mpc[i], mem_word(mpc[i])});
          mpc[i] = mpc[i] + 32'd4;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample_and_compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Entered 1ns after a rising edge; reset asserts between edges and is held across one edge.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    sample_and_compare();
    chk("rst_read_imm", 32'(bus0.imem_read), 32'd0);
    chk("rst_valid_imm", 32'(bus0.if_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int reads;
    model_reset();
    fetch_en = 1'b1;
    id_ready = 1'b1;
    @(posedge clk);
    #1;
    apply_reset();

    // Reset release and first fetches, including PC wrap on the second instance
    tick();
    chk("t1_c0_read", 32'(o_read[0]), 32'd1);
    chk("t1_c0_addr", o_addr[0], 32'h0);
    tick();
    chk("t1_c1_valid", 32'(o_valid[0]), 32'd1);
    chk("t1_c1_instr", o_instr[0], 32'h2048_000A);
    chk("t1_c1_pc", o_pc[0], 32'h0);
    chk("t4_c1_pc", o_pc[1], 32'hFFFF_FFFC);
    tick();
    chk("t1_c2_instr", o_instr[0], 32'h2849_000A);
    chk("t1_c2_pc", o_pc[0], 32'h4);
    chk("t4_c2_pc", o_pc[1], 32'h0);

    // Backpressure from a fresh reset
    apply_reset();
    id_ready = 1'b0;
    reads = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_read[0]) reads++;
    end
    chk("t2_push_count", 32'(reads), 32'd4);
    chk("t2_addr_held", bus0.imem_addr, 32'd16);
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
`ifdef IFU_PERF_CNT_EN
      if (k == 0) begin
        chk("t6_perf_fetch", pf[0], 32'd4);
        chk("t6_perf_stall", ps[0], 32'd4);
      end
`endif
      chk($sformatf("t2_order_%0d", k), o_pc[0], 32'(4 * k));
    end

    // Redirect with three entries buffered
    fetch_en = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    fetch_en = 1'b1;
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    tick();
    chk("t3_valid_low", 32'(o_valid[0]), 32'd0);
    chk("t3_addr", o_addr[0], 32'h40);
    tick();
    chk("t3_target_pc", o_pc[0], 32'h40);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      fetch_en       = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 1) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      tick();
    end

    // Asynchronous reset with two entries buffered
    redirect_valid = 1'b0;
    fetch_en = 1'b0;
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    fetch_en = 1'b1;
    id_ready = 1'b0;
    for (int k = 0; k < 2; k++) tick();
    chk("t5_two_entries", 32'(mq[0].size()), 32'd2);
    apply_reset();
    id_ready = 1'b1;
    tick();
    chk("t5_restart_u0", o_addr[0], 32'h0);
    chk("t5_restart_u1", o_addr[1], 32'hFFFF_FFFC);
    for (int k = 0; k < 6; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
